alu_hw_sequencer: RTL and testbench
===================================

Name: alu_hw_sequencer

Overview:
- Hardware stimulus sequencer for the accelerated ALU verification flow.
- Generates a programmed number of ALU input transactions on chip and presents them to the ALU input port with a valid/ready handshake.
- Generalises the software ALU sequence:
  - parametrised operand, opcode and MOVI widths;
  - selectable generation mode (random, sweep, corner);
  - programmable transaction count, seed reload, abort.

Parameters:
- DATA_WIDTH, 8, width of REG_A, MEM and IMM operands.
- OP_WIDTH, 4, opcode width.
- MOVI_WIDTH, 2, operand-select width.
- CNT_WIDTH, 16, width of transaction counters.
- DEFAULT_SEED, 64'h0123_4567_89AB_CDEF, LFSR seed after reset; must be nonzero.
- Constraint: 3*DATA_WIDTH+OP_WIDTH+MOVI_WIDTH <= 64.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous active-high reset.
- START  in  1  pulse; begins a run, sampled only in IDLE.
- ABORT  in  1  terminates a run, returns to IDLE.
- MODE  in  2  0 random, 1 sweep, 2 corner, 3 treated as random; latched at START.
- TRANS_COUNT  in  CNT_WIDTH  transactions per run; latched at START.
- SEED_LOAD  in  1  loads SEED_IN into LFSR; honoured only in IDLE.
- SEED_IN  in  64  new seed; value 0 replaced by DEFAULT_SEED.
- ALU_RDY  in  1  ALU accepts current transaction.
- TX_VLD  out  1  transaction valid.
- OUT_ACT  out  1  ALU activate; equals TX_VLD.
- OUT_OP  out  OP_WIDTH  opcode.
- OUT_MOVI  out  MOVI_WIDTH  operand select.
- OUT_REG_A  out  DATA_WIDTH  operand A.
- OUT_MEM  out  DATA_WIDTH  memory operand.
- OUT_IMM  out  DATA_WIDTH  immediate operand.
- BUSY  out  1  high in LOAD and RUN.
- DONE  out  1  one-cycle pulse at run completion.
- SENT_CNT  out  CNT_WIDTH  transactions accepted in current or last run.

Behaviour:
- Reset (any cycle, any state): state IDLE; LFSR=DEFAULT_SEED; all outputs 0; SENT_CNT=0.
- FSM states: IDLE, LOAD, RUN, FIN.
- IDLE:
  - SEED_LOAD=1 loads LFSR next cycle; SEED_LOAD has priority over START in the same cycle, and START is then ignored.
  - START=1: latch MODE and TRANS_COUNT, clear SENT_CNT, clear sweep/corner indices.
    - Go to LOAD, or to FIN if TRANS_COUNT=0.
- LOAD (one cycle): form the first transaction into output registers; TX_VLD=1 from the next cycle; go to RUN.
- RUN:
  - Transfer occurs when TX_VLD & ALU_RDY.
  - Without a transfer, all OUT_* are held stable and TX_VLD stays high.
  - On transfer: SENT_CNT+1.
    - If SENT_CNT+1 = TRANS_COUNT: TX_VLD=0 next cycle, go to FIN.
    - Otherwise: next transaction is registered the following cycle with TX_VLD still 1, giving back-to-back throughput of one per cycle when ALU_RDY stays high.
- FIN: DONE=1 for exactly one cycle, TX_VLD=0; go to IDLE.
- ABORT:
  - In LOAD or RUN: TX_VLD=0 next cycle; go to IDLE with no DONE pulse; SENT_CNT keeps the accepted count.
  - A transfer in the same cycle as ABORT is counted.
  - ABORT in IDLE or FIN has no effect.
- START during LOAD, RUN or FIN is ignored.
- Random mode:
  - 64-bit Fibonacci LFSR, polynomial x^64+x^63+x^61+x^60+1, shifting left with feedback into bit 0.
  - Advances exactly once per transaction formed (LOAD, and each non-final transfer).
  - Field slicing from the new LFSR value, LSB first: IMM, MEM, REG_A, OP, MOVI.
- Sweep mode:
  - Transaction k: OP = k mod 2^OP_WIDTH; MOVI = (k>>OP_WIDTH) mod 2^MOVI_WIDTH.
  - REG_A = k[DATA_WIDTH-1:0]; MEM = ~REG_A; IMM = REG_A+1, wrapping modulo 2^DATA_WIDTH.
- Corner mode:
  - Operand pattern index p cycles 0,1,2,3 per transaction, giving REG_A values 0, all-ones, 1, all-ones-1.
  - MEM and IMM use pattern (p+1) mod 4 and (p+2) mod 4.
  - OP increments every 4 transactions; MOVI = OP mod 2^MOVI_WIDTH.
- SENT_CNT saturates at all-ones and never wraps.
- LFSR state persists across runs unless reloaded or reset.

Test Plan:
- Reset mid-RUN after 3 transfers -> next cycle TX_VLD=0, BUSY=0, SENT_CNT=0, LFSR=DEFAULT_SEED; no DONE.
- MODE=1, TRANS_COUNT=5, ALU_RDY held 1 -> 5 consecutive transfers with OP=0..4, REG_A=0..4, MEM=FF..FB, IMM=1..5; DONE pulses once; SENT_CNT=5.
- MODE=0, ALU_RDY toggling 1,0,0,1 -> outputs stable through stall cycles; identical sequence to a model LFSR seeded with DEFAULT_SEED.
- SEED_LOAD with SEED_IN=0 and START in the same cycle -> LFSR=DEFAULT_SEED, START ignored, stays IDLE.
- TRANS_COUNT=0 START -> no TX_VLD; DONE one cycle after START; SENT_CNT=0.
- MODE=2, TRANS_COUNT=8, ABORT after 6th transfer (same cycle) -> SENT_CNT=6, REG_A seen 00,FF,01,FE,00,FF; no DONE; IDLE.

Source files
------------

// File: rtl/alu_hw_sequencer.sv
// On-chip ALU stimulus sequencer: forms random, sweep or corner-case ALU
// transactions and presents them with a valid/ready handshake.
module alu_hw_sequencer #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned OP_WIDTH     = 4,
    parameter int unsigned MOVI_WIDTH   = 2,
    parameter int unsigned CNT_WIDTH    = 16,
    parameter logic [63:0] DEFAULT_SEED = 64'h0123_4567_89AB_CDEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [1:0]            mode_i,
    input  logic [CNT_WIDTH-1:0]  trans_count_i,
    input  logic                  seed_load_i,
    input  logic [63:0]           seed_in_i,
    input  logic                  alu_rdy_i,
    output logic                  tx_vld_o,
    output logic                  out_act_o,
    output logic [OP_WIDTH-1:0]   out_op_o,
    output logic [MOVI_WIDTH-1:0] out_movi_o,
    output logic [DATA_WIDTH-1:0] out_reg_a_o,
    output logic [DATA_WIDTH-1:0] out_mem_o,
    output logic [DATA_WIDTH-1:0] out_imm_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_WIDTH-1:0]  sent_cnt_o
);

    localparam int unsigned OFS_MEM  = DATA_WIDTH;
    localparam int unsigned OFS_REGA = 2 * DATA_WIDTH;
    localparam int unsigned OFS_OP   = 3 * DATA_WIDTH;
    localparam int unsigned OFS_MOVI = 3 * DATA_WIDTH + OP_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    localparam logic [1:0] MODE_SWEEP  = 2'd1;
    localparam logic [1:0] MODE_CORNER = 2'd2;

    state_e                state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [CNT_WIDTH-1:0]  trans_q, trans_d;
    logic [CNT_WIDTH-1:0]  sent_q, sent_d;
    logic [CNT_WIDTH-1:0]  idx_q, idx_d;
    logic [63:0]           lfsr_q, lfsr_d;
    logic                  tx_vld_q, tx_vld_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [OP_WIDTH-1:0]   op_q, op_d;
    logic [MOVI_WIDTH-1:0] movi_q, movi_d;
    logic [DATA_WIDTH-1:0] reg_a_q, reg_a_d;
    logic [DATA_WIDTH-1:0] mem_q, mem_d;
    logic [DATA_WIDTH-1:0] imm_q, imm_d;

    logic [63:0]           lfsr_adv;
    logic                  is_random;
    logic [OP_WIDTH-1:0]   gen_op;
    logic [MOVI_WIDTH-1:0] gen_movi;
    logic [DATA_WIDTH-1:0] gen_reg_a;
    logic [DATA_WIDTH-1:0] gen_mem;
    logic [DATA_WIDTH-1:0] gen_imm;
    logic                  xfer;
    logic                  form;
    logic [CNT_WIDTH-1:0]  sent_inc;

    // Corner operand patterns: 0, all-ones, 1, all-ones-1
    function automatic logic [DATA_WIDTH-1:0] corner_pat(input logic [1:0] p);
        logic [DATA_WIDTH-1:0] v;
        case (p)
            2'd0:    v = '0;
            2'd1:    v = '1;
            2'd2:    v = DATA_WIDTH'(1);
            default: v = ~DATA_WIDTH'(1);
        endcase
        return v;
    endfunction

    // Candidate next transaction for the latched mode
    always_comb begin
        lfsr_adv  = {lfsr_q[62:0], lfsr_q[63] ^ lfsr_q[62] ^ lfsr_q[60] ^ lfsr_q[59]};
        is_random = 1'b0;
        gen_op    = '0;
        gen_movi  = '0;
        gen_reg_a = '0;
        gen_mem   = '0;
        gen_imm   = '0;
        case (mode_q)
            MODE_SWEEP: begin
                gen_reg_a = DATA_WIDTH'(idx_q);
                gen_mem   = ~gen_reg_a;
                gen_imm   = gen_reg_a + DATA_WIDTH'(1);
                gen_op    = OP_WIDTH'(idx_q);
                gen_movi  = MOVI_WIDTH'(idx_q >> OP_WIDTH);
            end
            MODE_CORNER: begin
                gen_reg_a = corner_pat(idx_q[1:0]);
                gen_mem   = corner_pat(idx_q[1:0] + 2'd1);
                gen_imm   = corner_pat(idx_q[1:0] + 2'd2);
                gen_op    = OP_WIDTH'(idx_q >> 2);
                gen_movi  = MOVI_WIDTH'(gen_op);
            end
            default: begin
                is_random = 1'b1;
                gen_imm   = lfsr_adv[0 +: DATA_WIDTH];
                gen_mem   = lfsr_adv[OFS_MEM +: DATA_WIDTH];
                gen_reg_a = lfsr_adv[OFS_REGA +: DATA_WIDTH];
                gen_op    = lfsr_adv[OFS_OP +: OP_WIDTH];
                gen_movi  = lfsr_adv[OFS_MOVI +: MOVI_WIDTH];
            end
        endcase
    end

    // Next-state and output logic
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        trans_d  = trans_q;
        sent_d   = sent_q;
        idx_d    = idx_q;
        lfsr_d   = lfsr_q;
        tx_vld_d = tx_vld_q;
        op_d     = op_q;
        movi_d   = movi_q;
        reg_a_d  = reg_a_q;
        mem_d    = mem_q;
        imm_d    = imm_q;
        form     = 1'b0;
        xfer     = tx_vld_q & alu_rdy_i;
        sent_inc = (&sent_q) ? sent_q : sent_q + CNT_WIDTH'(1);

        case (state_q)
            ST_IDLE: begin
                if (seed_load_i) begin
                    lfsr_d = (seed_in_i == 64'd0) ? DEFAULT_SEED : seed_in_i;
                end else if (start_i) begin
                    mode_d  = mode_i;
                    trans_d = trans_count_i;
                    sent_d  = '0;
                    idx_d   = '0;
                    state_d = (trans_count_i == '0) ? ST_FIN : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else begin
                    form     = 1'b1;
                    tx_vld_d = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    sent_d = sent_inc;
                end
                if (abort_i) begin
                    tx_vld_d = 1'b0;
                    state_d  = ST_IDLE;
                end else if (xfer) begin
                    if (sent_inc == trans_q) begin
                        tx_vld_d = 1'b0;
                        state_d  = ST_FIN;
                    end else begin
                        form = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (form) begin
            if (is_random) begin
                lfsr_d = lfsr_adv;
            end
            op_d    = gen_op;
            movi_d  = gen_movi;
            reg_a_d = gen_reg_a;
            mem_d   = gen_mem;
            imm_d   = gen_imm;
            idx_d   = idx_q + CNT_WIDTH'(1);
        end

        busy_d = (state_d == ST_LOAD) || (state_d == ST_RUN);
        done_d = (state_d == ST_FIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mode_q   <= '0;
            trans_q  <= '0;
            sent_q   <= '0;
            idx_q    <= '0;
            lfsr_q   <= DEFAULT_SEED;
            tx_vld_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            op_q     <= '0;
            movi_q   <= '0;
            reg_a_q  <= '0;
            mem_q    <= '0;
            imm_q    <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            trans_q  <= trans_d;
            sent_q   <= sent_d;
            idx_q    <= idx_d;
            lfsr_q   <= lfsr_d;
            tx_vld_q <= tx_vld_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            op_q     <= op_d;
            movi_q   <= movi_d;
            reg_a_q  <= reg_a_d;
            mem_q    <= mem_d;
            imm_q    <= imm_d;
        end
    end

    assign tx_vld_o    = tx_vld_q;
    assign out_act_o   = tx_vld_q;
    assign out_op_o    = op_q;
    assign out_movi_o  = movi_q;
    assign out_reg_a_o = reg_a_q;
    assign out_mem_o   = mem_q;
    assign out_imm_o   = imm_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign sent_cnt_o  = sent_q;

endmodule

// File: tb/tb_alu_hw_sequencer.sv
// Directed plus randomized bench for alu_hw_sequencer against a transaction-level model.
module tb_alu_hw_sequencer;

    localparam logic [63:0] DEF_SEED = 64'h0123_4567_89AB_CDEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, abort_i, seed_load_i, alu_rdy_i;
    logic [1:0]  mode_i;
    logic [15:0] trans_count_i;
    logic [63:0] seed_in_i;
    logic        tx_vld_o, out_act_o, busy_o, done_o;
    logic [3:0]  out_op_o;
    logic [1:0]  out_movi_o;
    logic [7:0]  out_reg_a_o, out_mem_o, out_imm_o;
    logic [15:0] sent_cnt_o;

    int checks = 0;
    int errors = 0;
    logic [63:0] model_lfsr;
    logic [7:0]  pat [4] = '{8'h00, 8'hFF, 8'h01, 8'hFE};

    alu_hw_sequencer dut (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
        .mode_i(mode_i), .trans_count_i(trans_count_i),
        .seed_load_i(seed_load_i), .seed_in_i(seed_in_i), .alu_rdy_i(alu_rdy_i),
        .tx_vld_o(tx_vld_o), .out_act_o(out_act_o), .out_op_o(out_op_o),
        .out_movi_o(out_movi_o), .out_reg_a_o(out_reg_a_o), .out_mem_o(out_mem_o),
        .out_imm_o(out_imm_o), .busy_o(busy_o), .done_o(done_o), .sent_cnt_o(sent_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Transaction k of a run as {op, movi, reg_a, mem, imm}
    task automatic model_gen(input int mode, input int k, output logic [29:0] t);
        logic [7:0] a, m, im;
        logic [3:0] op;
        logic [1:0] mv;
        int p;
        if (mode == 1) begin
            a  = 8'(k % 256);
            m  = 8'(255 - (k % 256));
            im = 8'((k + 1) % 256);
            op = 4'(k % 16);
            mv = 2'((k / 16) % 4);
        end else if (mode == 2) begin
            p  = k % 4;
            a  = pat[p];
            m  = pat[(p + 1) % 4];
            im = pat[(p + 2) % 4];
            op = 4'((k / 4) % 16);
            mv = 2'(((k / 4) % 16) % 4);
        end else begin
            model_lfsr = {model_lfsr[62:0],
                          model_lfsr[63] ^ model_lfsr[62] ^ model_lfsr[60] ^ model_lfsr[59]};
            im = model_lfsr[7:0];
            m  = model_lfsr[15:8];
            a  = model_lfsr[23:16];
            op = model_lfsr[27:24];
            mv = model_lfsr[29:28];
        end
        t = {op, mv, a, m, im};
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_vld"}, 64'(tx_vld_o), 64'd0);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
        chk({tag, "_done"}, 64'(done_o), 64'd0);
    endtask

    task automatic load_seed(input logic [63:0] s);
        @(negedge clk);
        seed_load_i = 1'b1;
        seed_in_i   = s;
        @(negedge clk);
        seed_load_i = 1'b0;
        model_lfsr  = (s == 64'd0) ? DEF_SEED : s;
    endtask

    // rdy_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
    // abort_at/stop_at: transfer number at which to abort / leave the run mid-flight (0 = never).
    task automatic do_run(input int mode, input int cnt, input int rdy_mode,
                          input int abort_at, input int stop_at);
        logic [29:0] exp_t;
        int acc = 0;
        int k = 0;
        bit fin = 0;
        bit aborted = 0;
        bit rdy;
        @(negedge clk);
        start_i       = 1'b1;
        mode_i        = 2'(mode);
        trans_count_i = 16'(cnt);
        @(negedge clk);
        start_i = 1'b0;
        if (cnt == 0) begin
            chk("zero_done", 64'(done_o), 64'd1);
            chk("zero_vld", 64'(tx_vld_o), 64'd0);
            chk("zero_busy", 64'(busy_o), 64'd0);
            chk("zero_sent", 64'(sent_cnt_o), 64'd0);
            @(negedge clk);
            check_idle("zero_after");
            return;
        end
        chk("load_busy", 64'(busy_o), 64'd1);
        chk("load_vld", 64'(tx_vld_o), 64'd0);
        model_gen(mode, k, exp_t);
        k++;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            alu_rdy_i = 1'b0;
            abort_i   = 1'b0;
            chk("run_vld", 64'(tx_vld_o), 64'd1);
            chk("run_act", 64'(out_act_o), 64'd1);
            chk("run_busy", 64'(busy_o), 64'd1);
            chk("run_done", 64'(done_o), 64'd0);
            chk("run_sent", 64'(sent_cnt_o), 64'(acc));
            chk("run_txn", 64'({out_op_o, out_movi_o, out_reg_a_o, out_mem_o, out_imm_o}), 64'(exp_t));
            case (rdy_mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            alu_rdy_i = rdy;
            if (rdy) begin
                acc++;
                if (acc == stop_at) begin
                    @(negedge clk);
                    alu_rdy_i = 1'b0;
                    return;
                end
                if (acc == abort_at) begin
                    abort_i = 1'b1;
                    aborted = 1;
                    fin = 1;
                    break;
                end
                if (acc == cnt) begin
                    fin = 1;
                    break;
                end
                model_gen(mode, k, exp_t);
                k++;
            end
        end
        chk("run_ended", 64'(fin), 64'd1);
        @(negedge clk);
        alu_rdy_i = 1'b0;
        abort_i   = 1'b0;
        chk("end_vld", 64'(tx_vld_o), 64'd0);
        chk("end_busy", 64'(busy_o), 64'd0);
        chk("end_sent", 64'(sent_cnt_o), 64'(acc));
        chk("end_done", 64'(done_o), aborted ? 64'd0 : 64'd1);
        @(negedge clk);
        check_idle("post_end");
    endtask

    initial begin
        rst = 1'b1;
        start_i = 1'b0; abort_i = 1'b0; seed_load_i = 1'b0; alu_rdy_i = 1'b0;
        mode_i = 2'd0; trans_count_i = 16'd0; seed_in_i = 64'd0;
        model_lfsr = DEF_SEED;
        repeat (3) @(negedge clk);
        check_idle("reset");
        chk("reset_sent", 64'(sent_cnt_o), 64'd0);
        chk("reset_txn", 64'({out_op_o, out_movi_o, out_reg_a_o, out_mem_o, out_imm_o}), 64'd0);
        rst = 1'b0;

        // Sweep, back-to-back
        do_run(1, 5, 0, 0, 0);
        // Random with stalls, from the reset seed
        do_run(0, 12, 1, 0, 0);
        // Corner, abort on the 6th transfer
        do_run(2, 8, 0, 6, 0);
        // Zero-length run
        do_run(0, 0, 0, 0, 0);

        // Seed load of zero beats START in the same cycle
        @(negedge clk);
        seed_load_i = 1'b1; seed_in_i = 64'd0; start_i = 1'b1; trans_count_i = 16'd4;
        @(negedge clk);
        seed_load_i = 1'b0; start_i = 1'b0;
        model_lfsr = DEF_SEED;
        check_idle("seedstart_a");
        @(negedge clk);
        check_idle("seedstart_b");
        do_run(3, 6, 2, 0, 0);

        // Reset in the middle of a run after 3 transfers
        do_run(0, 10, 0, 0, 3);
        rst = 1'b1;
        #1;
        check_idle("midreset");
        chk("midreset_sent", 64'(sent_cnt_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_lfsr = DEF_SEED;
        @(negedge clk);
        check_idle("midreset_after");
        do_run(0, 5, 0, 0, 0);

        // Randomized runs, some with fresh seeds and aborts
        for (int it = 0; it < 8; it++) begin
            int cnt;
            int ab;
            if (it % 2 == 1)
                load_seed({32'($urandom), 32'($urandom)});
            cnt = $urandom_range(1, 20);
            ab  = ($urandom_range(0, 2) == 0 && cnt > 1) ? $urandom_range(1, cnt - 1) : 0;
            do_run($urandom_range(0, 3), cnt, 2, ab, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
